// File: rtl/rx_rs232.sv
`default_nettype none
// ============================================================================
// rx_rs232 : UART receiver for the tx_rs232 11-bit frame (start, 8 data LSB
//            first, mark bit, stop); mid-bit sampling, valid/framing strobes.
//            Optional macro RX_MAJORITY_EN: 2-of-3 majority at each sample.
// Revision : 1.0
// ============================================================================
module rx_rs232 #(
  parameter int CLK_PER_BIT = 5208,
  parameter int CNT_W       = 16
) (
  input  logic       clk_s,
  input  logic       rst_s,
  input  logic       iRX,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oFERR,
  output logic       oBUSY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_MARK  = 3'd3,
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] c_half = CNT_W'(CLK_PER_BIT / 2);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_PER_BIT - 1);

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             mark_err_q, mark_err_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  logic             w_fall;
  logic             w_tick;
  logic             w_rx_bit;

  assign w_fall = rx_prev_q & ~rx_s_q;
  assign w_tick = (state_q == S_START) ? (timer_q == c_half) : (timer_q == c_last);

`ifdef RX_MAJORITY_EN
  // rx_meta_q is next cycle's rx_s, so the +1 sample is available without delay.
  assign w_rx_bit = (rx_prev_q & rx_s_q) | (rx_prev_q & rx_meta_q) | (rx_s_q & rx_meta_q);
`else
  assign w_rx_bit = rx_s_q;
`endif

  always_comb begin
    rx_meta_d  = iRX;
    rx_s_d     = rx_meta_q;
    rx_prev_d  = rx_s_q;
    state_d    = state_q;
    timer_d    = w_tick ? '0 : timer_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    mark_err_d = mark_err_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (w_fall) begin
          state_d = S_START;
          timer_d = CNT_W'(1);
        end
      end
      S_START: begin
        if (w_tick) begin
          if (w_rx_bit) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DATA;
            bit_idx_d  = '0;
            mark_err_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          shift_d = {w_rx_bit, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_MARK;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_MARK: begin
        if (w_tick) begin
          mark_err_d = ~w_rx_bit;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          // Leaving mid-stop-bit lets a back-to-back start edge be caught.
          if (!w_rx_bit) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end else if (mark_err_q) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      mark_err_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      mark_err_q <= mark_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign oDATA  = data_q;
  assign oVALID = valid_q;
  assign oFERR  = ferr_q;
  assign oBUSY  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx_rs232.sv
`default_nettype none
// ============================================================================
// tb_rx_rs232 : directed, table-driven bench for rx_rs232 at CLK_PER_BIT=12.
// Revision    : 1.0
// ============================================================================
module tb_rx_rs232;

  localparam int CPB       = 12;
  localparam int LAT       = 2 + CPB / 2 + 10 * CPB + 1;
  localparam int NO_GLITCH = 99;

  logic       clk = 1'b0;
  logic       rst_s;
  logic       iRX;
  logic [7:0] oDATA;
  logic       oVALID;
  logic       oFERR;
  logic       oBUSY;

  rx_rs232 #(.CLK_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk_s (clk),
    .rst_s (rst_s),
    .iRX   (iRX),
    .oDATA (oDATA),
    .oVALID(oVALID),
    .oFERR (oFERR),
    .oBUSY (oBUSY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder
  logic [7:0] vq[$];
  int         vc[$];
  int         nferr = 0;
  int         nboth = 0;
  always @(negedge clk) begin
    if (oVALID) begin
      vq.push_back(oDATA);
      vc.push_back(cyc);
    end
    if (oFERR) nferr++;
    if (oVALID && oFERR) nboth++;
  end

  int n_vec = 0;
  int n_err = 0;
  int fall_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b9, input logic stp, input int gbit);
    logic [10:0] bits;
    bits     = {stp, b9, d, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < CPB; j++) begin
        iRX = bits[i] ^ ((i == gbit + 1) && (j == CPB / 2));
        step(1);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       b9;
    logic       stp;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[4];
  int   v0, f0, t0;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    tbl[1] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    tbl[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    rst_s = 1'b1;
    iRX   = 1'b1;
    step(3);
    chk("rst_data", 32'(oDATA), 32'h00);
    chk("rst_valid", 32'(oVALID), 32'h0);
    chk("rst_ferr", 32'(oFERR), 32'h0);
    chk("rst_busy", 32'(oBUSY), 32'h0);
    rst_s = 1'b0;
    step(5);

    for (int k = 0; k < 4; k++) begin
      v0 = vq.size();
      f0 = nferr;
      send_frame(tbl[k].data, tbl[k].b9, tbl[k].stp, NO_GLITCH);
      step(20);
      if (tbl[k].exp_valid) begin
        chk($sformatf("vec%0d_nvalid", k), 32'(vq.size() - v0), 32'd1);
        if (vq.size() > v0) begin
          chk($sformatf("vec%0d_vdata", k), 32'(vq[v0]), 32'(tbl[k].exp_data));
          chk($sformatf("vec%0d_latency", k), 32'(vc[v0] - fall_cyc), 32'(LAT));
        end
      end else begin
        chk($sformatf("vec%0d_nvalid", k), 32'(vq.size() - v0), 32'd0);
      end
      chk($sformatf("vec%0d_nferr", k), 32'(nferr - f0), 32'(tbl[k].exp_ferr));
      chk($sformatf("vec%0d_data", k), 32'(oDATA), 32'(tbl[k].exp_data));
      chk($sformatf("vec%0d_busy", k), 32'(oBUSY), 32'h0);
    end

    // Back-to-back frames without an idle gap
    v0 = vq.size();
    f0 = nferr;
    send_frame(8'h00, 1'b1, 1'b1, NO_GLITCH);
    t0 = fall_cyc;
    send_frame(8'hFF, 1'b1, 1'b1, NO_GLITCH);
    step(20);
    chk("b2b_nvalid", 32'(vq.size() - v0), 32'd2);
    if (vq.size() >= v0 + 2) begin
      chk("b2b_data0", 32'(vq[v0]), 32'h00);
      chk("b2b_data1", 32'(vq[v0+1]), 32'hFF);
      chk("b2b_lat0", 32'(vc[v0] - t0), 32'(LAT));
      chk("b2b_gap", 32'(vc[v0+1] - vc[v0]), 32'(11 * CPB));
    end
    chk("b2b_nferr", 32'(nferr - f0), 32'd0);

    // False start: 3-cycle low pulse
    v0 = vq.size();
    f0 = nferr;
    iRX = 1'b0;
    step(3);
    iRX = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("fs_busy_at_sample", 32'(oBUSY), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("fs_busy_after", 32'(oBUSY), 32'h0);
    @(posedge clk);
    #1;
    step(10);
    chk("fs_nvalid", 32'(vq.size() - v0), 32'd0);
    chk("fs_nferr", 32'(nferr - f0), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1, NO_GLITCH);
    step(20);
    chk("fs_next_data", 32'(oDATA), 32'h3C);
    chk("fs_next_nvalid", 32'(vq.size() - v0), 32'd1);

    // Stop bit 0 followed by a held-low line
    v0 = vq.size();
    f0 = nferr;
    send_frame(8'h55, 1'b1, 1'b0, NO_GLITCH);
    step(50);
    chk("brk_nferr", 32'(nferr - f0), 32'd1);
    chk("brk_busy_low", 32'(oBUSY), 32'h1);
    chk("brk_data", 32'(oDATA), 32'h3C);
    iRX = 1'b1;
    step(5);
    chk("brk_busy_released", 32'(oBUSY), 32'h0);
    step(150);
    chk("brk_nvalid", 32'(vq.size() - v0), 32'd0);
    chk("brk_nferr_final", 32'(nferr - f0), 32'd1);

    // Reset pulse during data bit 4
    v0 = vq.size();
    f0 = nferr;
    iRX = 1'b0;
    step(CPB);
    iRX = 1'b1;
    step(4 * CPB + CPB / 2);
    chk("mid_busy_before_rst", 32'(oBUSY), 32'h1);
    rst_s = 1'b1;
    step(1);
    rst_s = 1'b0;
    chk("mid_rst_data", 32'(oDATA), 32'h00);
    chk("mid_rst_busy", 32'(oBUSY), 32'h0);
    chk("mid_rst_valid", 32'(oVALID), 32'h0);
    step(150);
    chk("mid_nvalid", 32'(vq.size() - v0), 32'd0);
    chk("mid_nferr", 32'(nferr - f0), 32'd0);
    send_frame(8'h7E, 1'b1, 1'b1, NO_GLITCH);
    step(20);
    chk("mid_next_data", 32'(oDATA), 32'h7E);
    chk("mid_next_nvalid", 32'(vq.size() - v0), 32'd1);

`ifdef RX_MAJORITY_EN
    // One-cycle glitch at the middle of data bit 2
    v0 = vq.size();
    send_frame(8'hA5, 1'b1, 1'b1, 2);
    step(20);
    chk("maj_nvalid", 32'(vq.size() - v0), 32'd1);
    chk("maj_data", 32'(oDATA), 32'hA5);
`endif

    chk("valid_ferr_exclusive", 32'(nboth), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
